inst_fetch_buf: RTL

Instruction fetch buffer between the PC generator and the ID stage. It issues a read to the synchronous instruction ROM for each fetch address, tags the returned word with its PC, and queues the pair in a small FIFO. The ID stage drains the FIFO. The block flushes on a taken branch and raises a stall request back to the pipeline controller when the FIFO cannot accept another fetch.

---
 rtl/inst_fetch_buf.sv | 105 ++++++++++
 1 files changed

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues ROM reads for fetch PCs, tags returned words, and queues {pc, inst} for ID.
// Latency: address issued in cycle t, visible on id_* in cycle t+2; no combinational path from rom_data_i.
// Backpressure: stallreq_o holds the PC while queued plus in-flight entries fill the FIFO; stall[2] holds the head.
module inst_fetch_buf #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          ce_i,
  input  logic          branch_flag_i,
  input  logic [5:0]    stall,
  output logic [AW-1:0] rom_addr_o,
  output logic          rom_ce_o,
  input  logic [DW-1:0] rom_data_i,
  output logic          stallreq_o,
  output logic          id_valid_o,
  output logic [AW-1:0] id_pc_o,
  output logic [DW-1:0] id_inst_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_pc_q   [DEPTH];
  logic [DW-1:0] mem_inst_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic          unused_stall;

  // Only stall[0] (PC held) and stall[2] (ID held) matter to this stage.
  assign unused_stall = ^{stall[5:3], stall[1]};

  // Occupancy counts the in-flight read so a push can never land in a full FIFO.
  assign occ        = {1'b0, count_q} + (CW+1)'(pend_q);
  assign stallreq_o = (occ >= (CW+1)'(DEPTH));

  assign issue      = ce_i & ~stall[0] & ~stallreq_o & ~branch_flag_i & ~rst;
  assign rom_ce_o   = issue;
  assign rom_addr_o = pc_i;

  // A read returning during a branch belongs to the wrong path and is dropped.
  assign push = pend_q & ~branch_flag_i;
  assign pop  = id_valid_o & ~stall[2];

  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = id_valid_o ? mem_pc_q[rd_ptr_q]   : '0;
  assign id_inst_o  = id_valid_o ? mem_inst_q[rd_ptr_q] : '0;

  // Next-state for pointers, occupancy and the in-flight read; a branch flushes after honouring the pop.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    pend_d    = issue;
    pend_pc_d = issue ? pc_i : pend_pc_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (branch_flag_i) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Entry storage: the returning ROM word is paired with the PC that requested it.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_pc_q[wr_ptr_q]   <= pend_pc_q;
      mem_inst_q[wr_ptr_q] <= rom_data_i;
    end
  end

endmodule
